dac_frame_rx: RTL

Serial frame receiver: the listening end of the DAC write link (active-low sync, din MSB first, 8-bit header + 16-bit value, 24 bits per frame).
- Oversamples the external sclk/sync_n/din lines on the system clock.
- Captures each complete frame and presents header/value in parallel with a one-cycle strobe.
- Used as an in-fabric DAC model for loopback test, and as a link monitor that flags malformed frames.

---
 rtl/dac_link_pkg.sv | 22 ++
 rtl/dac_frame_rx_if.sv | 12 +
 rtl/sync_edge_det.sv | 39 +++
 rtl/dac_frame_rx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dac_link_pkg.sv
// Shared DAC link definitions: field widths, frame length and error codes.
// Used by the DAC transmitter and by the dac_frame_rx receiver/monitor.
package dac_link_pkg;

    localparam int LINK_HDR_W   = 8;
    localparam int LINK_VAL_W   = 16;
    localparam int LINK_FRAME_W = LINK_HDR_W + LINK_VAL_W;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_SHORT = 2'd1,
        ERR_LONG  = 2'd2
    } err_code_e;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        WAIT_END  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/dac_frame_rx_if.sv
// Serial DAC link lines: sclk, active-low sync_n, din (MSB first).
// master = transmitter side (drives), slave = receiver side (samples).
interface dac_frame_rx_if;

    logic sclk;
    logic sync_n;
    logic din;

    modport master (output sclk, output sync_n, output din);
    modport slave  (input  sclk, input  sync_n, input  din);

endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer with rise/fall pulses from last stage vs delayed copy.
// Ports: clk, rst (sync, active high), d_i async in; sync_o, rise_o, fall_o.
module sync_edge_det #(
    parameter int   STAGES = 2,
    parameter logic PRESET = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              dly_q;
    logic              dly_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
        dly_d  = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{PRESET}};
            dly_q  <= PRESET;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = sync_o & ~dly_q;
    assign fall_o = ~sync_o & dly_q;

endmodule

// File: rtl/dac_frame_rx.sv
// Oversampling receiver/monitor for the DAC write link (hdr + value frames).
// Ports: clk, rst, link (slave), header/value, frame_valid/err, err_code, count.
module dac_frame_rx
    import dac_link_pkg::*;
#(
    parameter int HDR_W       = LINK_HDR_W,
    parameter int VAL_W       = LINK_VAL_W,
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLE_RISE = 0
) (
    input  logic               clk,
    input  logic               rst,
    dac_frame_rx_if.slave      link,
    output logic [HDR_W-1:0]   header,
    output logic [VAL_W-1:0]   value,
    output logic               frame_valid,
    output logic               frame_err,
    output logic [1:0]         err_code,
    output logic [15:0]        frame_count
);

    localparam int FRAME_W = HDR_W + VAL_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic sync_s, sync_rise, sync_fall;
    logic din_s, din_rise_unused, din_fall_unused;

    sync_edge_det #(.STAGES(SYNC_STAGES), .PRESET(1'b1)) u_sclk (
        .clk    (clk),
        .rst    (rst),
        .d_i    (link.sclk),
        .sync_o (sclk_s),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .PRESET(1'b1)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (link.sync_n),
        .sync_o (sync_s),
        .rise_o (sync_rise),
        .fall_o (sync_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .PRESET(1'b1)) u_din (
        .clk    (clk),
        .rst    (rst),
        .d_i    (link.din),
        .sync_o (din_s),
        .rise_o (din_rise_unused),
        .fall_o (din_fall_unused)
    );

    rx_state_e          state_q, state_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               long_q, long_d;
    logic [HDR_W-1:0]   header_q, header_d;
    logic [VAL_W-1:0]   value_q, value_d;
    logic               frame_valid_q, frame_valid_d;
    logic               frame_err_q, frame_err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [15:0]        frame_count_q, frame_count_d;

    logic sample;
    logic full;
    logic settled;

    logic unused_sclk;
    assign unused_sclk = sclk_s;

    assign sample = ((SAMPLE_RISE != 0) ? sclk_rise : sclk_fall) & ~sync_s;
    assign full   = (bit_cnt_q == CNT_W'(FRAME_W));
    // bit_cnt doubles as a settle timer in WAIT_IDLE: the synchronizer
    // presets read as "idle" until SYNC_STAGES real samples have arrived.
    assign settled = (bit_cnt_q >= CNT_W'(SYNC_STAGES));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_IDLE: if (settled && sync_s) state_d = IDLE;
            IDLE:      if (sync_fall) state_d = SHIFT;
            SHIFT: begin
                if (full) begin
                    state_d = WAIT_END;
                end else if (sync_rise) begin
                    state_d = IDLE;
                end
            end
            WAIT_END:  if (sync_s) state_d = IDLE;
            default:   state_d = WAIT_IDLE;
        endcase
    end

    always_comb begin
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        long_d        = long_q;
        header_d      = header_q;
        value_d       = value_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        err_code_d    = err_code_q;
        frame_count_d = frame_count_q;
        unique case (state_q)
            WAIT_IDLE: begin
                if (!settled) bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
            IDLE: begin
                if (sync_fall) begin
                    shreg_d   = '0;
                    bit_cnt_d = '0;
                    long_d    = 1'b0;
                end
            end
            SHIFT: begin
                if (full) begin
                    header_d      = shreg_q[FRAME_W-1:VAL_W];
                    value_d       = shreg_q[VAL_W-1:0];
                    frame_valid_d = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    err_code_d    = ERR_NONE;
                end else if (sync_rise) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_SHORT;
                end else if (sample) begin
                    shreg_d   = {shreg_q[FRAME_W-2:0], din_s};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            WAIT_END: begin
                if (sync_s) begin
                    if (long_q) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LONG;
                    end
                end else if (sample) begin
                    long_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            long_q        <= 1'b0;
            header_q      <= '0;
            value_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
            frame_count_q <= '0;
        end else begin
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            long_q        <= long_d;
            header_q      <= header_d;
            value_q       <= value_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign header      = header_q;
    assign value       = value_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign frame_count = frame_count_q;

endmodule
